// File: rtl/fifo_stream_reader_if.sv
// Bundle of FIFO read-port and output-stream signals for fifo_stream_reader.
// The master side is the reader; the slave side is FIFO plus downstream sink.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_r_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [1:0]            buf_count;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    input  m_ready,
    output fifo_r_en,
    output m_valid,
    output m_data,
    output buf_count
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    output m_ready,
    input  fifo_r_en,
    input  m_valid,
    input  m_data,
    input  buf_count
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO consumer presenting words on a valid/ready stream.
// A 3-entry buffer hides the FIFO's one-cycle read latency.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  fifo_stream_reader_if.master bus
);
  logic [DATA_WIDTH-1:0] mem_q [3];
  logic [1:0] wr_q, wr_d;
  logic [1:0] rd_q, rd_d;
  logic [1:0] occ_q, occ_d;
  logic       inflight_q, inflight_d;
  logic [2:0] pending;
  logic       pop;
  logic       capture;
  logic       accept;

  function automatic logic [1:0] wrap_inc(
    input logic [1:0] i
  );
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Pops depend only on registered state, never on m_ready.
  assign pending = {1'b0, occ_q}
                 + {2'b00, inflight_q};
  assign pop     = !bus.fifo_empty && !flush
                 && (pending < 3'd3);
  assign capture = inflight_q && !flush;
  assign accept  = (occ_q != 2'd0) && bus.m_ready;

  assign bus.fifo_r_en = pop;
  assign bus.m_valid   = (occ_q != 2'd0);
  assign bus.buf_count = occ_q;

  always_comb begin
    unique case (rd_q)
      2'd1:    bus.m_data = mem_q[1];
      2'd2:    bus.m_data = mem_q[2];
      default: bus.m_data = mem_q[0];
    endcase
  end

  always_comb begin
    wr_d       = wr_q;
    rd_d       = rd_q;
    occ_d      = occ_q;
    inflight_d = pop;
    if (flush) begin
      wr_d  = 2'd0;
      rd_d  = 2'd0;
      occ_d = 2'd0;
    end else begin
      if (capture) wr_d = wrap_inc(wr_q);
      if (accept)  rd_d = wrap_inc(rd_q);
      unique case ({capture, accept})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= 2'd0;
      rd_q       <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        mem_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < 3; i++)
        if (wr_q == i[1:0])
          mem_q[i] <= bus.fifo_rdata;
    end
  end
endmodule
